mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage plus MEM/WB register, directly downstream of EX.
//  Consumes the EX/MEM-latched ALU result (address), store operand and dest reg.
//  Performs byte/half/word loads and stores on an internal data memory.
//  Registers load data for WB; o_read_data_W is the forwarding source EX uses for read-data forwarding.
// PARAMETERS
//  INST_SZ      32  datapath width
//  MEM_ADDR_SZ  8   word-address bits; memory depth = 2**MEM_ADDR_SZ words
// PORTS
//  i_clk            in   1        clock, rising edge
//  i_reset          in   1        synchronous reset, active-low
//  i_enable         in   1        pipeline advance; 0 = stall (debug step)
//  i_alu_result_M   in   INST_SZ  byte address / ALU result
//  i_write_data_M   in   INST_SZ  store data (forwarded operand B)
//  i_instr_rd_M     in   5        destination register
//  i_mem_read_MC    in   1        load
//  i_mem_write_MC   in   1        store
//  i_reg_write_MC   in   1        writes register file
//  i_mem_to_reg_MC  in   1        WB selects load data
//  i_bhw_MC         in   3        [1:0] size 00=byte 01=half 11=word (10 = word); [2]=1 zero-extend
//  i_dbg_addr       in   MEM_ADDR_SZ  debug word address
//  o_dbg_data       out  INST_SZ  debug word read, combinational from array
//  o_read_data_W    out  INST_SZ  registered, extended load data
//  o_alu_result_W   out  INST_SZ  registered ALU result
//  o_instr_rd_W     out  5        registered dest reg
//  o_reg_write_W    out  1        registered reg write
//  o_mem_to_reg_W   out  1        registered mem-to-reg
//  o_misaligned_W   out  1        registered misaligned-access flag
// BEHAVIOUR
//  - Reset (i_reset=0 at edge): all W outputs 0; every memory word cleared to 0; overrides i_enable.
//  - i_enable=0: no memory write; all W registers hold.
//  - Latency 1: memory write and W register update on the same rising edge with i_enable=1.
//  - Word index = addr[MEM_ADDR_SZ+1:2]; upper address bits ignored (0x400 aliases 0x0 at default).
//  - Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1] (0 -> bits 15:0).
//  - Stores: byte writes only lane's 8 bits from data[7:0]; half writes 16 bits from data[15:0];
//    word writes all 32; other lanes unchanged.
//  - Loads: select lane; sign-extend when i_bhw_MC[2]=0, zero-extend when 1; word ignores [2].
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, only when read or write asserted:
//    no memory write; o_read_data_W=0; o_reg_write_W forced 0; o_misaligned_W=1 for that slot.
//  - Non-memory instr: o_read_data_W=0, o_misaligned_W=0, other fields pass through.
//  - Read and write both asserted: write performed; o_read_data_W returns pre-write contents.
//  - o_dbg_data reflects array contents after the last edge (no bypass of same-edge write).
// TESTING
//  1 Reset low 1 cycle -> all W outputs 0; o_dbg_data=0 for addresses 0,1,255.
//  2 sw 0x12345678 @0x10; lw @0x10 -> o_read_data_W=0x12345678 next cycle; lb @0x13 -> 0x00000012.
//  3 sb 0xAB @0x07 on zero word -> dbg word1=0xAB000000; lb @0x07 -> 0xFFFFFFAB; lbu -> 0x000000AB.
//  4 sh 0xBEEF @0x05 -> word1 unchanged, o_misaligned_W=1, o_reg_write_W=0; lh @0x06 of 0x8001 -> 0xFFFF8001.
//  5 i_enable=0 during sw 0xDEADBEEF @0x20 -> memory and W outputs unchanged; enable=1 -> write happens.
//  6 sw 0x55 @0x400 -> dbg word0=0x55 (wrap); reset mid-stream then lw @0x0 -> 0x00000000.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage with MEM/WB register: byte/half/word loads and stores on
// an internal word-organised data memory, registered results for write-back.
module mem_stage #(
   parameter int INST_SZ     = 32,
   parameter int MEM_ADDR_SZ = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_enable,
   input  logic [INST_SZ-1:0]     i_alu_result_M,
   input  logic [INST_SZ-1:0]     i_write_data_M,
   input  logic [4:0]             i_instr_rd_M,
   input  logic                   i_mem_read_MC,
   input  logic                   i_mem_write_MC,
   input  logic                   i_reg_write_MC,
   input  logic                   i_mem_to_reg_MC,
   input  logic [2:0]             i_bhw_MC,
   input  logic [MEM_ADDR_SZ-1:0] i_dbg_addr,
   output logic [INST_SZ-1:0]     o_dbg_data,
   output logic [INST_SZ-1:0]     o_read_data_W,
   output logic [INST_SZ-1:0]     o_alu_result_W,
   output logic [4:0]             o_instr_rd_W,
   output logic                   o_reg_write_W,
   output logic                   o_mem_to_reg_W,
   output logic                   o_misaligned_W
);

   localparam int unsigned DEPTH = 2 ** MEM_ADDR_SZ;

   logic [INST_SZ-1:0]     mem [DEPTH];
   logic [MEM_ADDR_SZ-1:0] word_idx;
   logic [1:0]             lane;
   logic                   zext;
   logic                   is_byte;
   logic                   is_half;
   logic                   is_word;
   logic                   misaligned;
   logic                   do_write;
   logic [INST_SZ-1:0]     cur_word;
   logic [INST_SZ-1:0]     store_word;
   logic [INST_SZ-1:0]     load_data;
   logic [7:0]             load_byte;
   logic [15:0]            load_half;

   // Upper address bits beyond the memory depth are ignored, so addresses alias.
   assign word_idx = i_alu_result_M[MEM_ADDR_SZ+1:2];
   assign lane     = i_alu_result_M[1:0];
   assign zext     = i_bhw_MC[2];
   assign is_byte  = (i_bhw_MC[1:0] == 2'b00);
   assign is_half  = (i_bhw_MC[1:0] == 2'b01);
   assign is_word  = i_bhw_MC[1];
   assign cur_word = mem[word_idx];

   assign misaligned = (i_mem_read_MC || i_mem_write_MC) &&
                       ((is_half && lane[0]) || (is_word && (lane != 2'b00)));
   assign do_write   = i_mem_write_MC && !misaligned;

   // Debug port shows the array as of the last edge, without same-edge bypass.
   assign o_dbg_data = mem[i_dbg_addr];

   // Merge store data into the addressed lane(s), leaving other lanes intact.
   always_comb begin
      store_word = cur_word;
      if (is_byte) begin
         case (lane)
            2'd0:    store_word[7:0]   = i_write_data_M[7:0];
            2'd1:    store_word[15:8]  = i_write_data_M[7:0];
            2'd2:    store_word[23:16] = i_write_data_M[7:0];
            default: store_word[31:24] = i_write_data_M[7:0];
         endcase
      end else if (is_half) begin
         if (lane[1]) store_word[31:16] = i_write_data_M[15:0];
         else         store_word[15:0]  = i_write_data_M[15:0];
      end else begin
         store_word = i_write_data_M;
      end
   end

   // Select the load lane and extend it to the datapath width.
   always_comb begin
      case (lane)
         2'd0:    load_byte = cur_word[7:0];
         2'd1:    load_byte = cur_word[15:8];
         2'd2:    load_byte = cur_word[23:16];
         default: load_byte = cur_word[31:24];
      endcase
      load_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
      if (is_byte)
         load_data = {{(INST_SZ-8){~zext & load_byte[7]}}, load_byte};
      else if (is_half)
         load_data = {{(INST_SZ-16){~zext & load_half[15]}}, load_half};
      else
         load_data = cur_word;
   end

   // Memory write and MEM/WB register update; reset clears both and beats enable.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         o_read_data_W  <= '0;
         o_alu_result_W <= '0;
         o_instr_rd_W   <= '0;
         o_reg_write_W  <= 1'b0;
         o_mem_to_reg_W <= 1'b0;
         o_misaligned_W <= 1'b0;
      end else if (i_enable) begin
         if (do_write) mem[word_idx] <= store_word;
         o_read_data_W  <= (i_mem_read_MC && !misaligned) ? load_data : '0;
         o_alu_result_W <= i_alu_result_M;
         o_instr_rd_W   <= i_instr_rd_M;
         o_reg_write_W  <= i_reg_write_MC && !misaligned;
         o_mem_to_reg_W <= i_mem_to_reg_MC;
         o_misaligned_W <= misaligned;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-array reference model, directed plus random ops.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] alu = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  rd = '0;
   logic        memr = 1'b0;
   logic        memw = 1'b0;
   logic        regw = 1'b0;
   logic        m2r = 1'b0;
   logic [2:0]  bhw = '0;
   logic [7:0]  dbg_addr = '0;
   logic [31:0] dbg_data;
   logic [31:0] rdata_w;
   logic [31:0] alu_w;
   logic [4:0]  rd_w;
   logic        regw_w;
   logic        m2r_w;
   logic        mis_w;

   mem_stage #(.INST_SZ(32), .MEM_ADDR_SZ(8)) dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable),
      .i_alu_result_M(alu), .i_write_data_M(wdata), .i_instr_rd_M(rd),
      .i_mem_read_MC(memr), .i_mem_write_MC(memw), .i_reg_write_MC(regw),
      .i_mem_to_reg_MC(m2r), .i_bhw_MC(bhw), .i_dbg_addr(dbg_addr),
      .o_dbg_data(dbg_data), .o_read_data_W(rdata_w), .o_alu_result_W(alu_w),
      .o_instr_rd_W(rd_w), .o_reg_write_W(regw_w), .o_mem_to_reg_W(m2r_w),
      .o_misaligned_W(mis_w)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
      logic        mis;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        last_exp = '0;
   logic [7:0]  ref_bytes [1024];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int unsigned w);
      return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
   endfunction

   // Monitor: one expected W snapshot per clock edge that the driver reported.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("read_data_W", rdata_w, e.rdata);
            chk("alu_result_W", alu_w, e.alu);
            chk("instr_rd_W", {27'd0, rd_w}, {27'd0, e.rd});
            chk("reg_write_W", {31'd0, regw_w}, {31'd0, e.rw});
            chk("mem_to_reg_W", {31'd0, m2r_w}, {31'd0, e.m2r});
            chk("misaligned_W", {31'd0, mis_w}, {31'd0, e.mis});
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      memw = 1'b1;
      alu = $urandom;
      wdata = $urandom;
      for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
      last_exp = '0;
      @(posedge clk);
      sb_q.push_back(last_exp);
      #1;
      reset = 1'b1;
      enable = 1'b0;
      memw = 1'b0;
   endtask

   task automatic op(input logic en, input logic [31:0] a, input logic [31:0] d,
                     input logic [4:0] r, input logic mr, input logic mw,
                     input logic rw, input logic mtr, input logic [2:0] b);
      exp_t        e;
      int unsigned ba;
      int unsigned nb;
      logic        mis;
      logic [31:0] ld;
      @(negedge clk);
      reset = 1'b1; enable = en; alu = a; wdata = d; rd = r;
      memr = mr; memw = mw; regw = rw; m2r = mtr; bhw = b;
      ba = int'(a[9:0]);
      nb = (b[1:0] == 2'b00) ? 1 : (b[1:0] == 2'b01) ? 2 : 4;
      mis = (mr || mw) && ((ba % nb) != 0);
      if (!en) begin
         e = last_exp;
      end else begin
         ld = '0;
         if (mr && !mis) begin
            for (int k = 0; k < int'(nb); k++) ld |= 32'(ref_bytes[ba+k]) << (8*k);
            if (nb < 4 && !b[2] && ld[8*nb-1]) ld |= 32'hFFFF_FFFF << (8*nb);
         end
         if (mw && !mis)
            for (int k = 0; k < int'(nb); k++) ref_bytes[ba+k] = 8'(d >> (8*k));
         e.rdata = ld;
         e.alu   = a;
         e.rd    = r;
         e.rw    = rw && !mis;
         e.m2r   = mtr;
         e.mis   = mis;
      end
      last_exp = e;
      @(posedge clk);
      sb_q.push_back(e);
      #1;
      enable = 1'b0;
   endtask

   task automatic dbg_const(input string name, input logic [7:0] w, input logic [31:0] val);
      @(negedge clk);
      dbg_addr = w;
      #1;
      chk(name, dbg_data, val);
   endtask

   task automatic dbg_model(input logic [7:0] w);
      @(negedge clk);
      dbg_addr = w;
      #1;
      chk("dbg_model", dbg_data, ref_word(int'(w)));
   endtask

   initial begin
      // 1: reset state
      do_reset();
      dbg_const("dbg_rst_0", 8'd0, 32'h0);
      dbg_const("dbg_rst_1", 8'd1, 32'h0);
      dbg_const("dbg_rst_255", 8'd255, 32'h0);
      // 2: word store, word load, byte load
      op(1, 32'h10, 32'h1234_5678, 5'd3, 0, 1, 0, 0, 3'b011);
      op(1, 32'h10, 32'h0, 5'd4, 1, 0, 1, 1, 3'b011);
      op(1, 32'h13, 32'h0, 5'd5, 1, 0, 1, 1, 3'b000);
      dbg_const("dbg_sw_w4", 8'd4, 32'h1234_5678);
      // 3: byte store and signed/unsigned byte loads
      op(1, 32'h07, 32'h0000_00AB, 5'd0, 0, 1, 0, 0, 3'b000);
      dbg_const("dbg_sb_w1", 8'd1, 32'hAB00_0000);
      op(1, 32'h07, 32'h0, 5'd6, 1, 0, 1, 1, 3'b000);
      op(1, 32'h07, 32'h0, 5'd7, 1, 0, 1, 1, 3'b100);
      // 4: misaligned half store, aligned half store/load
      op(1, 32'h05, 32'h0000_BEEF, 5'd8, 0, 1, 1, 0, 3'b001);
      dbg_const("dbg_mis_w1", 8'd1, 32'hAB00_0000);
      op(1, 32'h06, 32'h0000_8001, 5'd0, 0, 1, 0, 0, 3'b001);
      op(1, 32'h06, 32'h0, 5'd9, 1, 0, 1, 1, 3'b001);
      op(1, 32'h11, 32'h0, 5'd10, 1, 0, 1, 1, 3'b010);
      op(1, 32'h13, 32'h0, 5'd11, 0, 0, 1, 0, 3'b011);
      // read+write together returns pre-write contents
      op(1, 32'h10, 32'hCAFE_F00D, 5'd12, 1, 1, 1, 1, 3'b011);
      dbg_const("dbg_rw_w4", 8'd4, 32'hCAFE_F00D);
      // 5: stall blocks the write and holds W outputs
      op(0, 32'h20, 32'hDEAD_BEEF, 5'd13, 0, 1, 1, 0, 3'b011);
      dbg_const("dbg_stall_w8", 8'd8, 32'h0);
      op(1, 32'h20, 32'hDEAD_BEEF, 5'd13, 0, 1, 0, 0, 3'b011);
      dbg_const("dbg_en_w8", 8'd8, 32'hDEAD_BEEF);
      // 6: address wrap, then reset mid-stream clears memory
      op(1, 32'h400, 32'h55, 5'd14, 0, 1, 0, 0, 3'b011);
      dbg_const("dbg_wrap_w0", 8'd0, 32'h55);
      do_reset();
      op(1, 32'h0, 32'h0, 5'd15, 1, 0, 1, 1, 3'b011);
      dbg_const("dbg_rst2_w0", 8'd0, 32'h0);
      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) a |= ($urandom & 32'hFFFF_FC00);
         if ($urandom_range(0, 149) == 0) do_reset();
         op(($urandom_range(0, 7) != 0), a, $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
         if (n % 20 == 0) dbg_model(8'($urandom_range(0, 31)));
      end
      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
